dout_writer: RTL and testbench

DOUT_WRITER -- requirements
Module: dout_writer

---
 rtl/dout_writer.sv | 217 +++++++++++++++++++++
 tb/tb_dout_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dout_writer.sv
`default_nettype none
// ============================================================================
// Module      : dout_writer
// Description : Periodic 4-line serial frame transmitter. Every FRAME_PERIOD
//               clocks it latches eight 24-bit samples and shifts them out
//               MSB first on four data lines, framed by an active-low drdy_o
//               and a divided bit clock dclk_o.
// Revision    : 1.0 - initial release
// ============================================================================
module dout_writer #(
    parameter int CLK_DIV      = 4,    // clk_i cycles per dclk_o half-period
    parameter int FRAME_PERIOD = 512   // clk_i cycles between frame starts
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [23:0] ch1_i,
    input  logic [23:0] ch2_i,
    input  logic [23:0] ch3_i,
    input  logic [23:0] ch4_i,
    input  logic [23:0] ch5_i,
    input  logic [23:0] ch6_i,
    input  logic [23:0] ch7_i,
    input  logic [23:0] ch8_i,
    output logic        drdy_o,
    output logic        dclk_o,
    output logic        dout0_o,
    output logic        dout1_o,
    output logic        dout2_o,
    output logic        dout3_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o
);

    localparam int              c_TW      = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [c_TW-1:0] c_T_LAST  = c_TW'(FRAME_PERIOD - 1);
    localparam logic [7:0]      c_PH_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0]      c_NBITS   = 6'd48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_CLK_HI = 2'd2,
        ST_CLK_LO = 2'd3
    } state_t;

    // Registered state
    state_t           r_state;
    logic [c_TW-1:0]  r_timer;
    logic [7:0]       r_phase;      // cycle index within the current state
    logic [5:0]       r_bit;        // dclk_o rising edges issued this frame
    logic [3:0][47:0] r_sh;         // one 48-bit shift register per line
    logic             r_drdy;
    logic             r_dclk;
    logic [3:0]       r_dout;
    logic             r_busy;
    logic             r_done;
    logic             r_ovr;

    // Next-state values
    state_t           w_state_nx;
    logic [7:0]       w_phase_nx;
    logic [5:0]       w_bit_nx;
    logic [3:0][47:0] w_sh_nx;
    logic             w_drdy_nx;
    logic             w_dclk_nx;
    logic [3:0]       w_dout_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_ovr_nx;

    logic             w_req;
    logic             w_phase_end;

    assign w_req       = (r_timer == c_T_LAST);
    assign w_phase_end = (r_phase == c_PH_LAST);

    // Free-running frame timer; its last count is the frame request
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_timer <= '0;
        end else if (w_req) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TW'(1);
        end
    end

    // Next-state, datapath and output decode; every output is then registered
    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_bit_nx   = r_bit;
        w_sh_nx    = r_sh;
        w_drdy_nx  = r_drdy;
        w_dclk_nx  = r_dclk;
        w_dout_nx  = r_dout;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        // A request arriving while a frame runs is dropped and flagged
        w_ovr_nx   = w_req && (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_req && en_i) begin
                    w_state_nx = ST_SETUP;
                    w_phase_nx = 8'd0;
                    w_bit_nx   = 6'd0;
                    w_sh_nx    = {{ch7_i, ch8_i}, {ch5_i, ch6_i},
                                  {ch3_i, ch4_i}, {ch1_i, ch2_i}};
                    w_drdy_nx  = 1'b0;
                    w_dclk_nx  = 1'b0;
                    w_dout_nx  = {ch7_i[23], ch5_i[23], ch3_i[23], ch1_i[23]};
                    w_busy_nx  = 1'b1;
                end
            end

            ST_SETUP: begin
                if (w_phase_end) begin
                    w_state_nx = ST_CLK_HI;
                    w_phase_nx = 8'd0;
                    w_dclk_nx  = 1'b1;
                    w_bit_nx   = r_bit + 6'd1;
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end

            ST_CLK_HI: begin
                if (w_phase_end) begin
                    // Data advances only on the falling dclk edge
                    w_state_nx = ST_CLK_LO;
                    w_phase_nx = 8'd0;
                    w_dclk_nx  = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        w_sh_nx[i]   = {r_sh[i][46:0], 1'b0};
                        w_dout_nx[i] = r_sh[i][46];
                    end
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end

            ST_CLK_LO: begin
                if (w_phase_end) begin
                    w_phase_nx = 8'd0;
                    if (r_bit == c_NBITS) begin
                        w_state_nx = ST_IDLE;
                        w_bit_nx   = 6'd0;
                        w_drdy_nx  = 1'b1;
                        w_dclk_nx  = 1'b0;
                        w_dout_nx  = 4'd0;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_CLK_HI;
                        w_dclk_nx  = 1'b1;
                        w_bit_nx   = r_bit + 6'd1;
                    end
                end else begin
                    w_phase_nx = r_phase + 8'd1;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state, phase and bit counters
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
            r_phase <= 8'd0;
            r_bit   <= 6'd0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_bit   <= w_bit_nx;
        end
    end

    // Shift registers and registered outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sh   <= '0;
            r_drdy <= 1'b1;
            r_dclk <= 1'b0;
            r_dout <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_sh   <= w_sh_nx;
            r_drdy <= w_drdy_nx;
            r_dclk <= w_dclk_nx;
            r_dout <= w_dout_nx;
            r_busy <= w_busy_nx;
            r_done <= w_done_nx;
            r_ovr  <= w_ovr_nx;
        end
    end

    assign drdy_o    = r_drdy;
    assign dclk_o    = r_dclk;
    assign dout0_o   = r_dout[0];
    assign dout1_o   = r_dout[1];
    assign dout2_o   = r_dout[2];
    assign dout3_o   = r_dout[3];
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign overrun_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_dout_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dout_writer
// Description : Self-checking bench for dout_writer. Instance A uses default
//               timing, instance B a short frame period that forces overruns.
//               A frame-level reference model predicts every output per cycle;
//               a bench-side receiver recovers the transmitted words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dout_writer;

    localparam int C    = 4;
    localparam int FP0  = 512;
    localparam int FP1  = 300;
    localparam int FLEN = 97 * C;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b0;
    logic        en_i    = 1'b0;
    logic [23:0] ch [8];

    wire [1:0] drdy, dclk, busy, done, ovr;
    wire [3:0] doutA, doutB;

    always #5 clk_i = ~clk_i;

    dout_writer #(.CLK_DIV(C), .FRAME_PERIOD(FP0)) u_dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
        .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
        .drdy_o(drdy[0]), .dclk_o(dclk[0]),
        .dout0_o(doutA[0]), .dout1_o(doutA[1]), .dout2_o(doutA[2]), .dout3_o(doutA[3]),
        .busy_o(busy[0]), .done_o(done[0]), .overrun_o(ovr[0])
    );

    dout_writer #(.CLK_DIV(C), .FRAME_PERIOD(FP1)) u_dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
        .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
        .drdy_o(drdy[1]), .dclk_o(dclk[1]),
        .dout0_o(doutB[0]), .dout1_o(doutB[1]), .dout2_o(doutB[2]), .dout3_o(doutB[3]),
        .busy_o(busy[1]), .done_o(done[1]), .overrun_o(ovr[1])
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: elapsed cycle count, position k inside the frame
    // (-1 when idle), latched line words and the two pulse flags.
    int          m_t    [2];
    int          m_k    [2];
    logic [47:0] m_w    [2][4];
    logic        m_done [2];
    logic        m_ovr  [2];

    // Receiver on instance A
    logic        prev_drdy = 1'b1, prev_dclk = 1'b0;
    logic [47:0] rx [4];
    logic [47:0] last_rx [4];
    int edges = 0, low = 0, last_edges = 0, last_low = 0;
    int frames_done = 0, low_total = 0, ov_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Advance the model by one clock edge using the inputs held during it
    task automatic model_step();
        int fp;
        bit req;
        for (int i = 0; i < 2; i++) begin
            fp = (i == 0) ? FP0 : FP1;
            if (!reset_i) begin
                m_t[i] = 0; m_k[i] = -1; m_done[i] = 1'b0; m_ovr[i] = 1'b0;
            end else begin
                req = ((m_t[i] % fp) == fp - 1);
                m_done[i] = 1'b0;
                m_ovr[i]  = 1'b0;
                if (m_k[i] >= 0) begin
                    m_ovr[i] = req;
                    m_k[i]++;
                    if (m_k[i] == FLEN) begin
                        m_k[i] = -1;
                        m_done[i] = 1'b1;
                    end
                end else if (req && en_i) begin
                    m_k[i] = 0;
                    for (int l = 0; l < 4; l++) m_w[i][l] = {ch[2*l], ch[2*l+1]};
                end
                m_t[i]++;
            end
        end
    endtask

    // Expected {drdy,dclk,dout3..0,busy,done,ovr} from frame position
    function automatic logic [8:0] model_out(input int i);
        logic [3:0] d;
        logic dk;
        int k, b, w;
        d = 4'd0; dk = 1'b0; b = 0;
        if (m_k[i] < 0) return {1'b1, 1'b0, 4'd0, 1'b0, m_done[i], m_ovr[i]};
        k = m_k[i];
        if (k >= C) begin
            w  = (k - C) % (2 * C);
            dk = (w < C);
            b  = (k - C) / (2 * C) + ((w < C) ? 0 : 1);
        end
        for (int l = 0; l < 4; l++) d[l] = (b < 48) ? m_w[i][l][47 - b] : 1'b0;
        return {1'b0, dk, d, 1'b1, m_done[i], m_ovr[i]};
    endfunction

    // One clock: advance model, compare both DUTs, run the receiver
    task automatic tick();
        logic [8:0] got;
        @(negedge clk_i);
        cyc++;
        model_step();
        for (int i = 0; i < 2; i++) begin
            got = (i == 0) ? {drdy[0], dclk[0], doutA, busy[0], done[0], ovr[0]}
                           : {drdy[1], dclk[1], doutB, busy[1], done[1], ovr[1]};
            n_chk++;
            if (got === model_out(i)) n_pass++;
            else $display("FAIL outputs dut%0d cycle %0d: got %b expected %b (drdy,dclk,dout3..0,busy,done,ovr)",
                          i, cyc, got, model_out(i));
        end
        if (prev_drdy && !drdy[0]) begin
            for (int l = 0; l < 4; l++) rx[l] = 48'd0;
            edges = 0; low = 0;
        end
        if (!drdy[0]) begin low++; low_total++; end
        if (!prev_dclk && dclk[0]) begin
            edges++;
            for (int l = 0; l < 4; l++) rx[l] = {rx[l][46:0], doutA[l]};
        end
        if (done[0]) begin
            for (int l = 0; l < 4; l++) last_rx[l] = rx[l];
            last_edges = edges; last_low = low; frames_done++;
        end
        if (ovr[1]) ov_total++;
        prev_drdy = drdy[0];
        prev_dclk = dclk[0];
    endtask

    task automatic wait_done(input int budget);
        int f0, n;
        f0 = frames_done; n = 0;
        while (frames_done == f0 && n < budget) begin tick(); n++; end
        check("frame_done_in_budget", 64'(frames_done != f0), 64'd1);
    endtask

    // Wait until instance A is in the high phase after rising edge e
    task automatic wait_edge(input int e, input int budget);
        int n;
        n = 0;
        while (!(edges == e && dclk[0] && !drdy[0]) && n < budget) begin tick(); n++; end
        check("reach_bit_in_budget", 64'(edges == e && dclk[0] == 1'b1), 64'd1);
    endtask

    initial begin
        int s_low, s_ov, s_done, cnt;
        for (int l = 0; l < 4; l++) begin rx[l] = 48'd0; last_rx[l] = 48'd0; end
        ch[0] = 24'h123456; ch[1] = 24'hABCDEF; ch[2] = 24'h13579B; ch[3] = 24'h2468AC;
        ch[4] = 24'hFEDCBA; ch[5] = 24'h0F0F0F; ch[6] = 24'h5A5A5A; ch[7] = 24'hC3C3C3;

        // Reset state
        repeat (3) tick();
        check("reset_outputs_a", 64'({drdy[0], dclk[0], doutA, busy[0], done[0], ovr[0]}), 64'h100);
        en_i = 1'b1;
        reset_i = 1'b1;

        // Loopback with fixed words
        wait_done(1500);
        check("rx_line0", 64'(last_rx[0]), 64'h123456ABCDEF);
        check("rx_line1", 64'(last_rx[1]), 64'h13579B2468AC);
        check("rx_line2", 64'(last_rx[2]), 64'hFEDCBA0F0F0F);
        check("rx_line3", 64'(last_rx[3]), 64'h5A5A5AC3C3C3);
        check("dclk_rises", 64'(last_edges), 64'd48);
        check("drdy_low_cycles", 64'(last_low), 64'd388);
        check("overrun_b_count", 64'(ov_total), 64'd1);

        // Sign extremes
        ch[0] = 24'h800000; ch[1] = 24'h7FFFFF;
        wait_done(1200);
        check("rx_extremes", 64'(last_rx[0]), 64'h8000007FFFFF);

        // Input change during bit 10
        wait_edge(11, 1200);
        ch[0] = 24'h654321;
        wait_done(800);
        check("rx_latched_old", 64'(last_rx[0][47:24]), 64'h800000);
        wait_done(1200);
        check("rx_new_next_frame", 64'(last_rx[0][47:24]), 64'h654321);

        // Randomised traffic with occasional enable changes
        for (int n = 0; n < 12 * FP0; n++) begin
            tick();
            for (int j = 0; j < 8; j++) ch[j] = 24'($urandom);
            if ((n % 200) == 199) en_i = ($urandom_range(0, 3) != 0);
        end

        // Enable low at requests: no frames, no overruns
        en_i = 1'b0;
        repeat (FLEN + 20) tick();
        s_low = low_total; s_ov = ov_total;
        repeat (1024) tick();
        check("gated_drdy_low", 64'(low_total - s_low), 64'd0);
        check("gated_overrun", 64'(ov_total - s_ov), 64'd0);

        // Enable dropped at bit 20: frame completes, no further frames
        en_i = 1'b1;
        wait_edge(21, 1200);
        en_i = 1'b0;
        wait_done(800);
        check("en_drop_full_frame", 64'(last_edges), 64'd48);
        s_low = low_total;
        repeat (1100) tick();
        check("en_drop_no_restart", 64'(low_total - s_low), 64'd0);

        // Reset at bit 30
        en_i = 1'b1;
        wait_edge(31, 1200);
        s_done = frames_done;
        #1 reset_i = 1'b0;
        #1;
        check("reset_async_outputs", 64'({drdy[0], dclk[0], doutA, busy[0], done[0]}), 64'h80);
        repeat (3) tick();
        reset_i = 1'b1;
        cnt = 0;
        while (drdy[0] && cnt < 2000) begin tick(); cnt++; end
        check("restart_after_reset", 64'(cnt), 64'(FP0));
        check("no_done_on_abort", 64'(frames_done), 64'(s_done));
        wait_done(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
